// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - state encoding and parameter defaults for the reset sequencer
package rst_seq_pkg;

  localparam logic [1:0] ST_ASSERT  = 2'b00;
  localparam logic [1:0] ST_RELEASE = 2'b01;
  localparam logic [1:0] ST_IDLE    = 2'b10;

  localparam int unsigned NUM_DOMAINS_DEF    = 3;
  localparam int unsigned HOLD_CYCLES_DEF    = 16;
  localparam int unsigned STAGGER_CYCLES_DEF = 4;
  localparam int unsigned WDOG_TIMEOUT_DEF   = 1024;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/rst_seq_cnt.sv
// rtl/rst_seq_cnt.sv - clearable up-counter with terminal-count compare
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal value is always below the wrap point, so the counter never saturates.
  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staggered multi-domain reset sequencer; RST_SEQ_WDOG_EN adds an idle watchdog
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = NUM_DOMAINS_DEF,
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned STAGGER_CYCLES = STAGGER_CYCLES_DEF
`ifdef RST_SEQ_WDOG_EN
  , parameter int unsigned WDOG_TIMEOUT = WDOG_TIMEOUT_DEF
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sw_rst_req_i,
`ifdef RST_SEQ_WDOG_EN
  input  logic                   wdog_kick_i,
  output logic                   wdog_flag_o,
`endif
  output logic [NUM_DOMAINS-1:0] rst_out_o,
  output logic                   sw_rst_ack_o,
  output logic                   busy_o
);

  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_TERM = CNT_W'(STAGGER_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   armed_q, armed_d;
  logic                   served_q, served_d;
  logic                   accept;
  logic                   wdog_fire;
  logic                   cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]       cnt_term;

  assign accept = sw_rst_req_i && armed_q &&
                  ((state_q == ST_RELEASE) || (state_q == ST_IDLE));

  always_comb begin
    state_d   = state_q;
    rst_out_d = rst_out_q;
    armed_d   = armed_q;
    served_d  = served_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_term  = HOLD_TERM;

    if (!sw_rst_req_i) begin
      armed_d  = 1'b1;
      served_d = 1'b0;
    end

    if (accept || wdog_fire) begin
      state_d   = ST_ASSERT;
      rst_out_d = '0;
      cnt_clr   = 1'b1;
      if (accept) begin
        armed_d  = 1'b0;
        served_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_ASSERT: begin
          cnt_en    = 1'b1;
          rst_out_d = '0;
          if (cnt_tc) begin
            cnt_clr   = 1'b1;
            rst_out_d = NUM_DOMAINS'(1);
            state_d   = (&rst_out_d) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          cnt_en   = 1'b1;
          cnt_term = STAG_TERM;
          if (cnt_tc) begin
            // Released bits form a contiguous run from bit 0, so shift in the next one.
            cnt_clr   = 1'b1;
            rst_out_d = (rst_out_q << 1) | NUM_DOMAINS'(1);
            if (&rst_out_d) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          cnt_clr = 1'b1;
        end
        default: begin
          state_d   = ST_ASSERT;
          rst_out_d = '0;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_ASSERT;
      rst_out_q <= '0;
      armed_q   <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_out_q <= rst_out_d;
      armed_q   <= armed_d;
      served_q  <= served_d;
    end
  end

  rst_seq_cnt #(
    .WIDTH(CNT_W)
  ) u_seq_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .term_i(cnt_term),
    .tc_o  (cnt_tc)
  );

`ifdef RST_SEQ_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_TERM = WDOG_W'(WDOG_TIMEOUT - 1);

  logic wd_tc;
  logic wd_flag_q, wd_flag_d;
  logic wd_clr;

  assign wd_clr    = (state_q != ST_IDLE) || wdog_kick_i || wd_tc || accept;
  assign wdog_fire = (state_q == ST_IDLE) && wd_tc && !wdog_kick_i;
  assign wd_flag_d = wd_flag_q | wdog_fire;

  rst_seq_cnt #(
    .WIDTH(WDOG_W)
  ) u_wdog_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (wd_clr),
    .en_i  (state_q == ST_IDLE),
    .term_i(WDOG_TERM),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_flag_q <= 1'b0;
    end else begin
      wd_flag_q <= wd_flag_d;
    end
  end

  assign wdog_flag_o = wd_flag_q;
`else
  assign wdog_fire = 1'b0;
`endif

  assign rst_out_o    = rst_out_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign sw_rst_ack_o = (state_q == ST_IDLE) && served_q;

endmodule
